// File: rtl/alu_operand_stage_pkg.sv
// Shared widths, ALU opcodes, stage state encoding and the held-instruction record.
// Also hosts the WB snoop helper used on both capture and hold.
package alu_operand_stage_pkg;

  localparam int XLEN   = 64;
  localparam int REGW   = 5;
  localparam int OPW    = 3;
  localparam int STALLW = 32;

  localparam logic [OPW-1:0] ALU_ADD = 3'd0;
  localparam logic [OPW-1:0] ALU_SUB = 3'd1;
  localparam logic [OPW-1:0] ALU_AND = 3'd2;
  localparam logic [OPW-1:0] ALU_OR  = 3'd3;
  localparam logic [OPW-1:0] ALU_XOR = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_STALL = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [REGW-1:0] rd;
    logic [OPW-1:0]  op;
  } hdr_t;

  // The regfile has no write-through, so a same-cycle WB write must be merged by hand.
  function automatic logic [XLEN-1:0] wb_snoop(input logic [REGW-1:0] idx,
                                                input logic [XLEN-1:0] val,
                                                input logic            wb_wr_en,
                                                input logic [REGW-1:0] wb_rd,
                                                input logic [XLEN-1:0] wb_result);
    return (wb_wr_en && (idx != '0) && (wb_rd == idx)) ? wb_result : val;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side, bypass-side and ALU-side signals of the operand stage.
// master drives decode/bypass/ex_ready; slave is the stage itself.
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;

  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [REGW-1:0]   id_rs1;
  logic [REGW-1:0]   id_rs2;
  logic [XLEN-1:0]   id_rs1_val;
  logic [XLEN-1:0]   id_rs2_val;
  logic [XLEN-1:0]   id_imm;
  logic              id_use_imm;
  logic [REGW-1:0]   id_rd;
  logic [OPW-1:0]    id_alu_op;
  logic              mem_wr_en;
  logic              mem_is_load;
  logic [REGW-1:0]   mem_rd;
  logic [XLEN-1:0]   mem_result;
  logic              wb_wr_en;
  logic [REGW-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_result;
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [OPW-1:0]    alu_op;
  logic [REGW-1:0]   ex_rd;
  logic [STALLW-1:0] stall_cnt;

  modport master (
    output flush, id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           id_rd, id_alu_op, mem_wr_en, mem_is_load, mem_rd, mem_result,
           wb_wr_en, wb_rd, wb_result, ex_ready,
    input  id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rd, stall_cnt
  );

  modport slave (
    input  flush, id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           id_rd, id_alu_op, mem_wr_en, mem_is_load, mem_rd, mem_result,
           wb_wr_en, wb_rd, wb_result, ex_ready,
    output id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rd, stall_cnt
  );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Resolves one source operand: x0 -> 0, else MEM (non-load) > WB > held value.
// Purely combinational; no flow control of its own.
module alu_operand_stage_fwd_mux
  import alu_operand_stage_pkg::*;
(
  input  logic [REGW-1:0] idx,
  input  logic [XLEN-1:0] held_val,
  input  logic            mem_wr_en,
  input  logic            mem_is_load,
  input  logic [REGW-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_wr_en,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] operand
);

  always_comb begin
    operand = held_val;
    if (idx == '0) begin
      operand = '0;
    end else if (mem_wr_en && !mem_is_load && (mem_rd == idx)) begin
      operand = mem_result;
    end else if (wb_wr_en && (wb_rd == idx)) begin
      operand = wb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: one held instruction, operand forwarding, load-use stall, WB snoop.
// Capture at edge N gives ex_valid in cycle N+1; id_ready = empty || ex fire, 1 instr/cycle.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_operand_stage_if.slave io
);

  stage_state_e      state_q, state_d, cur_state;
  hdr_t              held_q, held_d;
  logic [STALLW-1:0] stall_cnt_q, stall_cnt_d;
  logic              held_valid, hazard, ex_valid, ex_fire, id_ready, capture;
  logic [XLEN-1:0]   fwd_a, fwd_b;

  assign held_valid = (state_q != ST_EMPTY);
  assign hazard = held_valid && io.mem_wr_en && io.mem_is_load && (io.mem_rd != '0) &&
                  ((held_q.rs1 == io.mem_rd) ||
                   (!held_q.use_imm && (held_q.rs2 == io.mem_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      held_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Only EMPTY/HELD are ever registered; STALL is HELD qualified by the live hazard.
  always_comb begin
    state_d = state_q;
    unique case (cur_state)
      ST_EMPTY: if (capture) state_d = ST_HELD;
      ST_HELD:  if (ex_fire && !capture) state_d = ST_EMPTY;
      ST_STALL: state_d = ST_HELD;
      default:  state_d = ST_EMPTY;
    endcase
    if (io.flush) state_d = ST_EMPTY;
  end

  always_comb begin
    cur_state = state_q;
    if (held_valid && hazard) cur_state = ST_STALL;
    ex_valid = (cur_state == ST_HELD);
    ex_fire  = ex_valid && io.ex_ready;
    id_ready = !held_valid || ex_fire;
    capture  = io.id_valid && id_ready && !io.flush;
  end

  always_comb begin
    held_d = held_q;
    held_d.rs1_val = wb_snoop(held_q.rs1, held_q.rs1_val, io.wb_wr_en, io.wb_rd, io.wb_result);
    held_d.rs2_val = wb_snoop(held_q.rs2, held_q.rs2_val, io.wb_wr_en, io.wb_rd, io.wb_result);
    if (capture) begin
      held_d.rs1     = io.id_rs1;
      held_d.rs2     = io.id_rs2;
      held_d.rs1_val = wb_snoop(io.id_rs1, io.id_rs1_val, io.wb_wr_en, io.wb_rd, io.wb_result);
      held_d.rs2_val = wb_snoop(io.id_rs2, io.id_rs2_val, io.wb_wr_en, io.wb_rd, io.wb_result);
      held_d.imm     = io.id_imm;
      held_d.use_imm = io.id_use_imm;
      held_d.rd      = io.id_rd;
      held_d.op      = io.id_alu_op;
    end

    stall_cnt_d = stall_cnt_q;
    if ((cur_state == ST_STALL) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  alu_operand_stage_fwd_mux u_fwd_a (
    .idx         (held_q.rs1),
    .held_val    (held_q.rs1_val),
    .mem_wr_en   (io.mem_wr_en),
    .mem_is_load (io.mem_is_load),
    .mem_rd      (io.mem_rd),
    .mem_result  (io.mem_result),
    .wb_wr_en    (io.wb_wr_en),
    .wb_rd       (io.wb_rd),
    .wb_result   (io.wb_result),
    .operand     (fwd_a)
  );

  alu_operand_stage_fwd_mux u_fwd_b (
    .idx         (held_q.rs2),
    .held_val    (held_q.rs2_val),
    .mem_wr_en   (io.mem_wr_en),
    .mem_is_load (io.mem_is_load),
    .mem_rd      (io.mem_rd),
    .mem_result  (io.mem_result),
    .wb_wr_en    (io.wb_wr_en),
    .wb_rd       (io.wb_rd),
    .wb_result   (io.wb_result),
    .operand     (fwd_b)
  );

  assign io.ex_valid  = ex_valid;
  assign io.id_ready  = id_ready;
  assign io.alu_a     = fwd_a;
  assign io.alu_b     = held_q.use_imm ? held_q.imm : fwd_b;
  assign io.alu_op    = held_q.op;
  assign io.ex_rd     = held_q.rd;
  assign io.stall_cnt = stall_cnt_q;

endmodule
